// File: rtl/i_imm_pkg.sv
// rtl/i_imm_pkg.sv - opcode keys, ALU/PC/data selects, FSM states and cw packing for i_imm_sequencer
// States S_MOVK1/S_MOVK2 exist only when I_IMM_MOVK_EN is defined.
package i_imm_pkg;

    localparam logic [9:0] OP_ADDI  = 10'b1001000100;
    localparam logic [9:0] OP_ADDIS = 10'b1011000100;
    localparam logic [9:0] OP_SUBI  = 10'b1101000100;
    localparam logic [9:0] OP_SUBIS = 10'b1111000100;
    localparam logic [9:0] OP_ANDI  = 10'b1001001000;
    localparam logic [9:0] OP_ANDIS = 10'b1111001000;
    localparam logic [9:0] OP_ORRI  = 10'b1011001000;
    localparam logic [9:0] OP_EORI  = 10'b1101001000;
    localparam logic [8:0] OP_MOVZ  = 9'b110100101;
    localparam logic [8:0] OP_MOVK  = 9'b111100101;

    localparam logic [4:0] FSEL_AND = 5'b00000;
    localparam logic [4:0] FSEL_OR  = 5'b00100;
    localparam logic [4:0] FSEL_ADD = 5'b01000;
    localparam logic [4:0] FSEL_SUB = 5'b01001;
    localparam logic [4:0] FSEL_XOR = 5'b01100;

    localparam logic [1:0] PSEL_HOLD = 2'b00;
    localparam logic [1:0] PSEL_INC  = 2'b01;
    localparam logic [1:0] DSEL_ALU  = 2'b01;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
`ifdef I_IMM_MOVK_EN
        S_MOVK1 = 2'd2,
        S_MOVK2 = 2'd3,
`endif
        S_ONE   = 2'd1
    } state_t;

    // Low 12 bits of a cw: {Fsel, regW, ramW, Dsel, Bsel, PCsel, SL}; every word writes Rd from the ALU with K.
    function automatic logic [11:0] pack_cw_lo(input logic [4:0] fsel, input logic sl);
        return {fsel, 1'b1, 1'b0, DSEL_ALU, 1'b1, 1'b0, sl};
    endfunction

endpackage

// File: rtl/i_imm_decode.sv
// rtl/i_imm_decode.sv - combinational instr -> {cw_a, cw_b, k_a, k_b, two_step, bad}
// MOVK decodes as a two-step AND/OR pair only when I_IMM_MOVK_EN is defined.
module i_imm_decode
    import i_imm_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int REG_AW = 5
) (
    input  logic [31:0]           instr,
    output logic [3*REG_AW+13:0]  cw_a,
    output logic [3*REG_AW+13:0]  cw_b,
    output logic [DATA_W-1:0]     k_a,
    output logic [DATA_W-1:0]     k_b,
    output logic                  two_step,
    output logic                  bad
);

    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rn;
    logic [REG_AW-1:0] zr;
    logic [5:0]        sh;
    logic              hw_bad;
    logic [DATA_W-1:0] imm16_k;
    logic [4:0]        fsel;
    logic              sl;
    logic              ari;

    always_comb begin
        rd      = REG_AW'(instr[4:0]);
        rn      = REG_AW'(instr[9:5]);
        zr      = REG_AW'(5'd31);
        sh      = {instr[22:21], 4'b0000};
        hw_bad  = int'(sh) >= DATA_W;
        imm16_k = DATA_W'(instr[20:5]) << sh;

        fsel = FSEL_ADD;
        sl   = 1'b0;
        ari  = 1'b1;
        case (instr[31:22])
            OP_ADDI:  fsel = FSEL_ADD;
            OP_ADDIS: begin fsel = FSEL_ADD; sl = 1'b1; end
            OP_SUBI:  fsel = FSEL_SUB;
            OP_SUBIS: begin fsel = FSEL_SUB; sl = 1'b1; end
            OP_ANDI:  fsel = FSEL_AND;
            OP_ANDIS: begin fsel = FSEL_AND; sl = 1'b1; end
            OP_ORRI:  fsel = FSEL_OR;
            OP_EORI:  fsel = FSEL_XOR;
            default:  ari = 1'b0;
        endcase

        cw_a     = '0;
        cw_b     = '0;
        k_a      = '0;
        k_b      = '0;
        two_step = 1'b0;
        bad      = 1'b0;
        if (ari) begin
            cw_a = {PSEL_INC, rd, rn, REG_AW'(0), pack_cw_lo(fsel, sl)};
            k_a  = DATA_W'(instr[21:10]);
        end else if (instr[31:23] == OP_MOVZ) begin
            bad  = hw_bad;
            cw_a = {PSEL_INC, rd, zr, REG_AW'(0), pack_cw_lo(FSEL_OR, 1'b0)};
            k_a  = imm16_k;
`ifdef I_IMM_MOVK_EN
        end else if (instr[31:23] == OP_MOVK) begin
            // Clear the target halfword with PC held, then OR the new halfword in and advance.
            bad      = hw_bad;
            two_step = 1'b1;
            cw_a     = {PSEL_HOLD, rd, rd, REG_AW'(0), pack_cw_lo(FSEL_AND, 1'b0)};
            k_a      = ~(DATA_W'(16'hFFFF) << sh);
            cw_b     = {PSEL_INC, rd, rd, REG_AW'(0), pack_cw_lo(FSEL_OR, 1'b0)};
            k_b      = imm16_k;
`endif
        end else begin
            bad = 1'b1;
        end
    end

endmodule

// File: rtl/i_imm_sequencer.sv
// rtl/i_imm_sequencer.sv - registered I-format immediate sequencer, one or two cw per instruction
// Optional MOVK two-step sequencing under I_IMM_MOVK_EN.
module i_imm_sequencer
    import i_imm_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int REG_AW = 5,
    localparam int CW_W = 3*REG_AW+14
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [CW_W-1:0]   cw,
    output logic [DATA_W-1:0] k,
    output logic              cw_valid,
    input  logic              cw_ready,
    output logic              illegal
);

    state_t            state;
    logic [CW_W-1:0]   cw_a;
    logic [CW_W-1:0]   cw_b;
    logic [DATA_W-1:0] k_a;
    logic [DATA_W-1:0] k_b;
    logic              two_step;
    logic              bad;
    logic              accept;

    i_imm_decode #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_decode (
        .instr    (instr),
        .cw_a     (cw_a),
        .cw_b     (cw_b),
        .k_a      (k_a),
        .k_b      (k_b),
        .two_step (two_step),
        .bad      (bad)
    );

`ifdef I_IMM_MOVK_EN
    logic [CW_W-1:0]   pend_cw;
    logic [DATA_W-1:0] pend_k;

    assign instr_ready = (state == S_EMPTY) |
                         (((state == S_ONE) | (state == S_MOVK2)) & cw_ready);
`else
    logic unused_movk;

    assign unused_movk = ^{cw_b, k_b, two_step};
    assign instr_ready = (state == S_EMPTY) | ((state == S_ONE) & cw_ready);
`endif

    assign accept = instr_valid & instr_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_EMPTY;
            cw       <= '0;
            k        <= '0;
            cw_valid <= 1'b0;
            illegal  <= 1'b0;
`ifdef I_IMM_MOVK_EN
            pend_cw  <= '0;
            pend_k   <= '0;
`endif
        end else begin
            illegal <= 1'b0;
            case (state)
`ifdef I_IMM_MOVK_EN
                S_MOVK1: begin
                    if (cw_ready) begin
                        cw    <= pend_cw;
                        k     <= pend_k;
                        state <= S_MOVK2;
                    end
                end
`endif
                default: begin
                    // Any accept here implies the word on display (if any) is being consumed.
                    if (accept) begin
                        if (bad) begin
                            illegal  <= 1'b1;
                            cw_valid <= 1'b0;
                            state    <= S_EMPTY;
                        end else begin
                            cw       <= cw_a;
                            k        <= k_a;
                            cw_valid <= 1'b1;
`ifdef I_IMM_MOVK_EN
                            pend_cw  <= cw_b;
                            pend_k   <= k_b;
                            state    <= two_step ? S_MOVK1 : S_ONE;
`else
                            state    <= S_ONE;
`endif
                        end
                    end else if ((state != S_EMPTY) && cw_ready) begin
                        cw_valid <= 1'b0;
                        state    <= S_EMPTY;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i_imm_sequencer.sv
// tb/tb_i_imm_sequencer.sv - scoreboard bench for i_imm_sequencer against a behavioural decode model
module tb_i_imm_sequencer;

    localparam int DW = 64;

    typedef struct {
        logic [28:0] cw;
        logic [63:0] k;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [28:0] cw;
    logic [63:0] k;
    logic        cw_valid;
    logic        cw_ready = 1'b0;
    logic        illegal;

    logic [31:0] instr32 = '0;
    logic        instr_valid32 = 1'b0;
    logic        instr_ready32;
    logic [28:0] cw32;
    logic [31:0] k32;
    logic        cw_valid32;
    logic        cw_ready32 = 1'b1;
    logic        illegal32;

    int   tests = 0;
    int   fails = 0;
    int   remaining = 0;
    logic exp_ill = 1'b0;
    exp_t exp_q[$];

    i_imm_sequencer #(.DATA_W(64), .REG_AW(5)) dut (
        .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .cw(cw), .k(k), .cw_valid(cw_valid),
        .cw_ready(cw_ready), .illegal(illegal)
    );

    i_imm_sequencer #(.DATA_W(32), .REG_AW(5)) dut32 (
        .clock(clock), .reset(reset), .instr(instr32), .instr_valid(instr_valid32),
        .instr_ready(instr_ready32), .cw(cw32), .k(k32), .cw_valid(cw_valid32),
        .cw_ready(cw_ready32), .illegal(illegal32)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic logic [28:0] make_cw(input logic [1:0] psel, input logic [4:0] da,
                                            input logic [4:0] sa, input logic [4:0] fsel,
                                            input logic sl);
        return {psel, da, sa, 5'd0, fsel, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, sl};
    endfunction

    // Number and content of the cw words an accepted instruction must produce (0 = illegal).
    function automatic void ref_decode(input logic [31:0] ins, output int n,
                                       output exp_t e1, output exp_t e2);
        logic [4:0] rd;
        logic [4:0] rn;
        logic [4:0] fsel;
        logic       sl;
        logic       known;
        int         sh;
        rd = ins[4:0];
        rn = ins[9:5];
        sh = 16 * int'(ins[22:21]);
        n = 0;
        e1.cw = '0; e1.k = '0;
        e2.cw = '0; e2.k = '0;
        known = 1'b1;
        fsel = 5'b01000;
        sl = 1'b0;
        case (ins[31:22])
            10'b1001000100: begin fsel = 5'b01000; sl = 1'b0; end
            10'b1011000100: begin fsel = 5'b01000; sl = 1'b1; end
            10'b1101000100: begin fsel = 5'b01001; sl = 1'b0; end
            10'b1111000100: begin fsel = 5'b01001; sl = 1'b1; end
            10'b1001001000: begin fsel = 5'b00000; sl = 1'b0; end
            10'b1111001000: begin fsel = 5'b00000; sl = 1'b1; end
            10'b1011001000: begin fsel = 5'b00100; sl = 1'b0; end
            10'b1101001000: begin fsel = 5'b01100; sl = 1'b0; end
            default: known = 1'b0;
        endcase
        if (known) begin
            n = 1;
            e1.cw = make_cw(2'b01, rd, rn, fsel, sl);
            e1.k  = 64'(ins[21:10]);
        end else if (ins[31:23] == 9'b110100101) begin
            if (sh < DW) begin
                n = 1;
                e1.cw = make_cw(2'b01, rd, 5'd31, 5'b00100, 1'b0);
                e1.k  = 64'(ins[20:5]) << sh;
            end
        end else if (ins[31:23] == 9'b111100101) begin
`ifdef I_IMM_MOVK_EN
            if (sh < DW) begin
                n = 2;
                e1.cw = make_cw(2'b00, rd, rd, 5'b00000, 1'b0);
                e1.k  = ~(64'hFFFF << sh);
                e2.cw = make_cw(2'b01, rd, rd, 5'b00100, 1'b0);
                e2.k  = 64'(ins[20:5]) << sh;
            end
`endif
        end
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 11))
            0:  r[31:22] = 10'b1001000100;
            1:  r[31:22] = 10'b1011000100;
            2:  r[31:22] = 10'b1101000100;
            3:  r[31:22] = 10'b1111000100;
            4:  r[31:22] = 10'b1001001000;
            5:  r[31:22] = 10'b1111001000;
            6:  r[31:22] = 10'b1011001000;
            7:  r[31:22] = 10'b1101001000;
            8:  r[31:23] = 9'b110100101;
            9:  r[31:23] = 9'b111100101;
            10: r = $urandom;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    // One clock: drive at posedge+1, check handshake at negedge, advance the model at posedge.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic rdy);
        logic exp_rdy;
        logic acc;
        logic con;
        int   n;
        exp_t e1;
        exp_t e2;
        instr_valid = v;
        instr = ins;
        cw_ready = rdy;
        @(negedge clock);
        exp_rdy = (remaining == 0) || (remaining == 1 && rdy);
        check("instr_ready", 64'(instr_ready), 64'(exp_rdy));
        check("cw_valid", 64'(cw_valid), 64'(remaining != 0));
        check("illegal", 64'(illegal), 64'(exp_ill));
        acc = v && exp_rdy;
        con = (remaining != 0) && rdy;
        @(posedge clock);
        if (con) remaining--;
        exp_ill = 1'b0;
        if (acc) begin
            ref_decode(ins, n, e1, e2);
            remaining = n;
            if (n == 0) exp_ill = 1'b1;
            if (n >= 1) exp_q.push_back(e1);
            if (n == 2) exp_q.push_back(e2);
        end
        #1;
    endtask

    logic        hold_prev = 1'b0;
    logic [28:0] prev_cw;
    logic [63:0] prev_k;

    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_cw", 64'(cw), 64'(prev_cw));
                check("hold_k", k, prev_k);
            end
            if (cw_valid && cw_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL cw_unexpected: got cw %h, want no word", cw);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_cw", 64'(cw), 64'(e.cw));
                    check("sb_k", k, e.k);
                end
            end
            hold_prev = cw_valid && !cw_ready;
            prev_cw = cw;
            prev_k = k;
        end
    end

    localparam logic [31:0] I_ADDI  = 32'h91001441;
    localparam logic [31:0] I_SUBIS = {10'b1111000100, 12'hFFF, 5'd4, 5'd3};
    localparam logic [31:0] I_MOVK  = {9'b111100101, 2'b10, 16'hBEEF, 5'd7};

    initial begin
        logic rv;
        logic rr;
        repeat (3) @(posedge clock);
        #1;
        check("rst_cw", 64'(cw), 64'd0);
        check("rst_k", k, 64'd0);
        check("rst_cw_valid", 64'(cw_valid), 64'd0);
        check("rst_illegal", 64'(illegal), 64'd0);
        reset = 1'b1;
        #1;
        check("rst_instr_ready", 64'(instr_ready), 64'd1);

        cycle(1'b1, I_ADDI, 1'b1);
        check("addi_cw", 64'(cw), 64'(make_cw(2'b01, 5'd1, 5'd2, 5'b01000, 1'b0)));
        check("addi_k", k, 64'd5);
        cycle(1'b0, 32'h0, 1'b1);

        cycle(1'b1, I_SUBIS, 1'b0);
        check("subis_fsel", 64'(cw[11:7]), 64'(5'b01001));
        check("subis_sl", 64'(cw[0]), 64'd1);
        check("subis_k", k, 64'hFFF);
        repeat (3) cycle(1'b0, 32'h0, 1'b0);
        check("subis_stall_ready", 64'(instr_ready), 64'd0);
        cycle(1'b0, 32'h0, 1'b1);

        cycle(1'b1, I_MOVK, 1'b1);
`ifdef I_IMM_MOVK_EN
        check("movk1_cw", 64'(cw), 64'(make_cw(2'b00, 5'd7, 5'd7, 5'b00000, 1'b0)));
        check("movk1_k", k, 64'hFFFF0000FFFFFFFF);
        cycle(1'b0, 32'h0, 1'b1);
        check("movk2_cw", 64'(cw), 64'(make_cw(2'b01, 5'd7, 5'd7, 5'b00100, 1'b0)));
        check("movk2_k", k, 64'h0000BEEF00000000);
`else
        check("movk_off_illegal", 64'(illegal), 64'd1);
        check("movk_off_valid", 64'(cw_valid), 64'd0);
`endif
        cycle(1'b0, 32'h0, 1'b1);

        cycle(1'b1, 32'h0, 1'b1);
        check("op0_illegal", 64'(illegal), 64'd1);
        check("op0_cw_valid", 64'(cw_valid), 64'd0);
        cycle(1'b0, 32'h0, 1'b1);

        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, {10'b1011001000, 12'(i + 1), 5'(i), 5'(i + 8)}, 1'b1);
            check("orri_stream_valid", 64'(cw_valid), 64'd1);
            check("orri_stream_k", k, 64'(i + 1));
        end
        cycle(1'b0, 32'h0, 1'b1);

        instr32 = {9'b110100101, 2'b10, 16'h1234, 5'd3};
        instr_valid32 = 1'b1;
        cycle(1'b0, 32'h0, 1'b1);
        check("dw32_movz_hw2_illegal", 64'(illegal32), 64'd1);
        check("dw32_movz_hw2_valid", 64'(cw_valid32), 64'd0);
        instr32 = {9'b110100101, 2'b01, 16'h1234, 5'd3};
        cycle(1'b0, 32'h0, 1'b1);
        check("dw32_movz_hw1_valid", 64'(cw_valid32), 64'd1);
        check("dw32_movz_hw1_k", 64'(k32), 64'h12340000);
        instr_valid32 = 1'b0;
        cycle(1'b0, 32'h0, 1'b1);

`ifdef I_IMM_MOVK_EN
        cycle(1'b1, I_MOVK, 1'b0);
        check("pre_reset_psel", 64'(cw[28:27]), 64'd0);
`else
        cycle(1'b1, I_ADDI, 1'b0);
`endif
        reset = 1'b0;
        #1;
        check("midrst_cw", 64'(cw), 64'd0);
        check("midrst_k", k, 64'd0);
        check("midrst_cw_valid", 64'(cw_valid), 64'd0);
        check("midrst_illegal", 64'(illegal), 64'd0);
        remaining = 0;
        exp_ill = 1'b0;
        exp_q.delete();
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (3) cycle(1'b0, 32'h0, 1'b1);

        for (int i = 0; i < 1500; i++) begin
            rv = $urandom_range(0, 3) != 0;
            rr = $urandom_range(0, 3) != 0;
            cycle(rv, rand_instr(), rr);
        end

        for (int i = 0; i < 8 && remaining != 0; i++) cycle(1'b0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
